morse_tx_param: RTL and testbench

//  Parametrised Morse transmitter: accepts one letter pattern (MSB-first bit string,
//  1 = lit, 0 = dark) plus its length over a start/ready handshake and plays it on

---
 rtl/morse_tx_param.sv | 160 ++++++++++++++++
 tb/tb_morse_tx_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_tx_param.sv
// Morse letter transmitter: plays an MSB-first lit/dark pattern of programmable length
// on morse_out, one bit per TICK_DIV clocks, then a dark inter-letter gap.
module morse_tx_param #(
    parameter int PATTERN_W = 16,
    parameter int LEN_W     = 5,
    parameter int TICK_DIV  = 25000000,
    parameter int GAP_TICKS = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [LEN_W-1:0]     length,
    input  logic                 repeat_en,
    input  logic                 abort,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 morse_out,
    output logic [1:0]           state_dbg
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int GAP_W   = $clog2(GAP_TICKS + 1);
    localparam logic [PRESC_W-1:0] RELOAD   = PRESC_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]   GAP_INIT = GAP_W'(GAP_TICKS);
    localparam logic [LEN_W-1:0]   MAX_LEN  = LEN_W'(PATTERN_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [PRESC_W-1:0]   presc, presc_n;
    logic [PATTERN_W-1:0] shreg, shreg_n;
    logic [PATTERN_W-1:0] hold, hold_n;
    logic [LEN_W-1:0]     len, len_n;
    logic [LEN_W-1:0]     remaining, remaining_n;
    logic [GAP_W-1:0]     gap_cnt, gap_cnt_n;
    logic                 morse_q, morse_n;
    logic                 tick;
    logic [LEN_W-1:0]     len_clamped;

    assign tick        = (presc == '0);
    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            presc     <= '0;
            shreg     <= '0;
            hold      <= '0;
            len       <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            morse_q   <= 1'b0;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            shreg     <= shreg_n;
            hold      <= hold_n;
            len       <= len_n;
            remaining <= remaining_n;
            gap_cnt   <= gap_cnt_n;
            morse_q   <= morse_n;
        end
    end

    always_comb begin
        state_n     = state;
        presc_n     = presc;
        shreg_n     = shreg;
        hold_n      = hold;
        len_n       = len;
        remaining_n = remaining;
        gap_cnt_n   = gap_cnt;
        morse_n     = morse_q;

        case (state)
            IDLE: begin
                morse_n = 1'b0;
                if (start && !abort) begin
                    shreg_n     = pattern;
                    hold_n      = pattern;
                    len_n       = len_clamped;
                    remaining_n = len_clamped;
                    presc_n     = RELOAD;
                    if (len_clamped == '0) begin
                        state_n = FIN;
                    end else begin
                        state_n = SEND;
                        morse_n = pattern[PATTERN_W-1];
                    end
                end
            end
            SEND: begin
                if (tick) begin
                    presc_n     = RELOAD;
                    shreg_n     = shreg << 1;
                    remaining_n = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_n   = GAP;
                        gap_cnt_n = GAP_INIT;
                        morse_n   = 1'b0;
                    end else begin
                        morse_n = shreg[PATTERN_W-2];
                    end
                end else begin
                    presc_n = presc - PRESC_W'(1);
                end
            end
            GAP: begin
                morse_n = 1'b0;
                if (tick) begin
                    presc_n   = RELOAD;
                    gap_cnt_n = gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) begin
                        // repeat_en is only looked at here, at the close of the gap
                        if (repeat_en) begin
                            state_n     = SEND;
                            shreg_n     = hold;
                            remaining_n = len;
                            morse_n     = hold[PATTERN_W-1];
                        end else begin
                            state_n = FIN;
                        end
                    end
                end else begin
                    presc_n = presc - PRESC_W'(1);
                end
            end
            FIN: begin
                state_n = IDLE;
                presc_n = '0;
                morse_n = 1'b0;
            end
            default: begin
                state_n = IDLE;
                morse_n = 1'b0;
            end
        endcase

        if (abort && state != IDLE) begin
            state_n = IDLE;
            presc_n = '0;
            morse_n = 1'b0;
        end
    end

    assign ready     = (state == IDLE);
    assign busy      = ~ready;
    // an abort arriving in FIN cancels the completion pulse in the same cycle
    assign done      = (state == FIN) && !abort;
    assign morse_out = morse_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_morse_tx_param.sv
// Self-checking bench for morse_tx_param: table vectors, random letters against a
// waveform model, plus reset, abort, repeat and busy-start sequences.
module tb_morse_tx_param;

    localparam int PW = 16;
    localparam int LW = 5;
    localparam int TD = 4;
    localparam int GT = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [PW-1:0] pattern;
    logic [LW-1:0] length;
    logic          repeat_en;
    logic          abort;
    logic          ready;
    logic          busy;
    logic          done;
    logic          morse_out;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];   // {ready, done, morse_out} per cycle after accept

    typedef struct {
        logic [PW-1:0] pat;
        logic [LW-1:0] len;
        int            exp_done;
    } vec_t;

    vec_t vecs[7];

    morse_tx_param #(
        .PATTERN_W(PW),
        .LEN_W    (LW),
        .TICK_DIV (TD),
        .GAP_TICKS(GT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .pattern  (pattern),
        .length   (length),
        .repeat_en(repeat_en),
        .abort    (abort),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .morse_out(morse_out),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output for cycle k after the accept edge, straight from the letter rules.
    function automatic logic [2:0] model(input logic [PW-1:0] pat, input int n,
                                         input int reps, input int k);
        int p, t, idx;
        logic m;
        p = (n + GT) * TD;
        t = (n == 0) ? 0 : reps * p;
        if (k < t) begin
            idx = (k % p) / TD;
            m = (idx < n) ? pat[PW-1-idx] : 1'b0;
            return {2'b00, m};
        end
        if (k == t) return 3'b010;
        return 3'b100;
    endfunction

    task automatic wait_idle();
        int c = 0;
        while (ready !== 1'b1 && c < 200) begin
            @(negedge clock);
            c++;
        end
        if (ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: ready=%b expected 1", ready);
        end
    endtask

    // Plays one letter (reps plays with repeat), optionally scrambling inputs and
    // pulsing start while busy; compares every cycle against the model.
    task automatic run_letter(input logic [PW-1:0] pat, input logic [LW-1:0] len_in,
                              input int reps, input bit noise, input string name,
                              output int done_k);
        int n, p, t;
        logic [2:0] e;
        n = (int'(len_in) > PW) ? PW : int'(len_in);
        p = (n + GT) * TD;
        t = (n == 0) ? 0 : reps * p;
        wait_idle();
        exp_q.delete();
        for (int k = 0; k <= t + 1; k++) exp_q.push_back(model(pat, n, reps, k));
        @(negedge clock);
        pattern   = pat;
        length    = len_in;
        start     = 1'b1;
        abort     = 1'b0;
        repeat_en = (reps > 1);
        @(negedge clock);
        done_k = -1;
        for (int k = 0; k <= t + 1; k++) begin
            e = exp_q.pop_front();
            check({name, "_out"}, {29'd0, ready, done, morse_out}, {29'd0, e});
            check({name, "_busy"}, {31'd0, busy}, {31'd0, ~e[2]});
            if (done === 1'b1 && done_k < 0) done_k = k;
            start = (noise && k < t) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                pattern = PW'($urandom);
                length  = LW'($urandom_range(0, 31));
            end
            repeat_en = (k < t - p / 2);
            if (k < t + 1) @(negedge clock);
        end
        start     = 1'b0;
        repeat_en = 1'b0;
    endtask

    initial begin
        int dk;
        logic [PW-1:0] rp;
        logic [LW-1:0] rl;

        vecs[0] = '{16'hA000, 5'd3,  24};
        vecs[1] = '{16'hB800, 5'd5,  32};
        vecs[2] = '{16'hFFFF, 5'd20, 76};
        vecs[3] = '{16'h1234, 5'd0,  0};
        vecs[4] = '{16'h8001, 5'd16, 76};
        vecs[5] = '{16'h4000, 5'd2,  20};
        vecs[6] = '{16'hC3FF, 5'd1,  16};

        reset = 1'b0; start = 1'b0; pattern = '0; length = '0;
        repeat_en = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_outs", {29'd0, ready, busy, done, morse_out}, 32'b1000);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_outs", {29'd0, ready, busy, done, morse_out}, 32'b1000);

        // table vectors
        for (int i = 0; i < 7; i++) begin
            run_letter(vecs[i].pat, vecs[i].len, 1, (i % 2) == 1, $sformatf("vec%0d", i), dk);
            check($sformatf("vec%0d_done_at", i), dk, vecs[i].exp_done);
        end

        // repeat mode with inputs changing and start pulses while busy
        run_letter(16'hB800, 5'd5, 3, 1'b1, "repeat", dk);
        check("repeat_done_at", dk, 96);

        // random letters
        for (int i = 0; i < 10; i++) begin
            rp = PW'($urandom);
            rl = LW'($urandom_range(0, 20));
            run_letter(rp, rl, (rl == 0) ? 1 : int'($urandom_range(1, 2)), 1'b1,
                       $sformatf("rand%0d", i), dk);
        end

        // asynchronous reset mid-letter
        wait_idle();
        @(negedge clock);
        pattern = 16'hFFFF; length = 5'd16; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("pre_rst_morse", {31'd0, morse_out}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_outs", {29'd0, ready, busy, done, morse_out}, 32'b1000);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_release_outs", {29'd0, ready, busy, done, morse_out}, 32'b1000);

        // abort during the second bit
        @(negedge clock);
        pattern = 16'hB800; length = 5'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("abort_first_bit", {31'd0, morse_out}, 32'd1);
        repeat (5) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_outs", {29'd0, ready, busy, done, morse_out}, 32'b1000);
        dk = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done === 1'b1 || ready !== 1'b1) dk++;
        end
        check("abort_quiet", dk, 0);

        // abort together with start in IDLE
        abort = 1'b1; start = 1'b1; pattern = 16'hFFFF; length = 5'd4;
        @(negedge clock);
        abort = 1'b0; start = 1'b0;
        check("abort_start_idle", {29'd0, ready, busy, done, morse_out}, 32'b1000);
        repeat (4) @(negedge clock);
        check("abort_start_still_idle", {30'd0, ready, morse_out}, 32'b10);

        // abort while the completion cycle is showing
        pattern = 16'hA000; length = 5'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (24) @(negedge clock);
        abort = 1'b1;
        #1;
        check("abort_fin_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        abort = 1'b0;
        check("abort_fin_ready", {30'd0, ready, done}, 32'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
